// File: rtl/aq32_bus_interconnect.sv
// aq32 CPU-to-slave interconnect.
// The CPU address is decoded against NUM_SLAVES base/mask windows, and a one-hot
// slave strobe is driven for the window that hits. The block inserts the read wait
// state for registered block-RAM slaves and replicates byte-wide read data onto all
// four lanes. Unmapped accesses and slaves that stay stalled too long are reported
// on m_error.
//
// Handshake: the CPU raises m_strobe and holds m_addr/m_wren stable while m_wait is
// high. The transaction completes in the cycle where m_strobe && !m_wait. If m_error
// is set in that cycle, the access failed and m_rddata is 0. If m_strobe drops before
// completion, the transaction is aborted and the interconnect is idle on the next cycle.
module aq32_bus_interconnect #(
    parameter int                         NUM_SLAVES = 6,
    parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE   = '0,
    parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK   = '0,
    parameter logic [NUM_SLAVES-1:0]      SYNC_RD    = '0,
    parameter logic [NUM_SLAVES-1:0]      BYTE_RD    = '0,
    parameter int                         TIMEOUT    = 1023
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  m_addr,
    input  logic                         m_wren,
    input  logic                         m_strobe,
    output logic                         m_wait,
    output logic [31:0]                  m_rddata,
    output logic                         m_error,
    output logic [NUM_SLAVES-1:0]        s_strobe,
    input  logic [NUM_SLAVES-1:0]        s_wait,
    input  logic [32*NUM_SLAVES-1:0]     s_rddata,
    output logic [1:0]                   dbg_state
);

    // The counter is one bit wide even when the timeout is disabled (TIMEOUT == 0).
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_ACCESS = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt, cnt_inc;
    logic                    hit, sel_sync, sel_byte, sel_wait, timeout_hit;
    logic [31:0]             sel_data;
    logic [NUM_SLAVES-1:0]   sel_onehot;
    logic                    wait_o, error_o;
    logic [31:0]             rd_o;
    logic [NUM_SLAVES-1:0]   strobe_o;

    // Address decode. The loop scans from high to low index, so the lowest matching window wins.
    always_comb begin
        hit        = 1'b0;
        sel_sync   = 1'b0;
        sel_byte   = 1'b0;
        sel_wait   = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((m_addr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
                hit           = 1'b1;
                sel_sync      = SYNC_RD[k];
                sel_byte      = BYTE_RD[k];
                sel_wait      = s_wait[k] & ~SYNC_RD[k];
                sel_data      = s_rddata[32*k +: 32];
                sel_onehot    = '0;
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Saturating wait counter increment, and detection of an expired timeout.
    always_comb begin
        cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
        timeout_hit = (TIMEOUT != 0) && (state == S_ACCESS) && (cnt == CW'(TIMEOUT));
    end

    // State and wait-counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. When strobe is low, the transaction is aborted and the counter is cleared.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!m_strobe) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!hit) begin
                        state_nxt = S_ERR;
                    end else if (sel_sync) begin
                        state_nxt = m_wren ? S_IDLE : S_SYNC;
                    end else if (sel_wait) begin
                        state_nxt = S_ACCESS;
                        cnt_nxt   = cnt_inc;
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                S_SYNC: begin
                    state_nxt = S_IDLE;
                end
                S_ACCESS: begin
                    if (timeout_hit || !sel_wait) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt   = cnt_inc;
                    end
                end
                S_ERR: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode. While reset is low, all outputs are forced to 0.
    always_comb begin
        wait_o   = 1'b0;
        error_o  = 1'b0;
        rd_o     = '0;
        strobe_o = '0;
        if (m_strobe) begin
            case (state)
                S_IDLE: begin
                    if (!hit)          wait_o = 1'b1;
                    else if (sel_sync) wait_o = !m_wren;
                    else               wait_o = sel_wait;
                end
                S_SYNC:   wait_o = 1'b0;
                S_ACCESS: begin
                    if (timeout_hit) error_o = 1'b1;
                    else             wait_o  = sel_wait;
                end
                S_ERR:    error_o = 1'b1;
                default:  wait_o  = 1'b0;
            endcase
            if (hit && (state != S_ERR) && !timeout_hit) begin
                strobe_o = sel_onehot;
                if (!m_wren)
                    rd_o = sel_byte ? {4{sel_data[7:0]}} : sel_data;
            end
        end
        m_wait    = wait_o & reset_n;
        m_error   = error_o & reset_n;
        m_rddata  = reset_n ? rd_o : 32'h0;
        s_strobe  = reset_n ? strobe_o : '0;
        dbg_state = state;
    end

endmodule

// File: tb/tb_aq32_bus_interconnect.sv
// Testbench for aq32_bus_interconnect. It uses three windows: an async slave (0), an
// async byte-wide slave (1) and a registered-read slave (2), with a timeout of 8 cycles.
// A transaction-level model predicts every output in every cycle. Directed sequences pin
// the model with literal values, and randomized traffic follows them.
module tb_aq32_bus_interconnect;

    localparam int          N  = 3;
    localparam int          TO = 8;
    localparam logic [95:0] BASE = {32'hFFFFF800, 32'hFF000000, 32'hFFF00000};
    localparam logic [95:0] MASK = {32'hFFFFF800, 32'hFFFFF000, 32'hFFF80000};
    localparam logic [2:0]  SYNC = 3'b100;
    localparam logic [2:0]  BYTE = 3'b010;
    localparam logic [95:0] RD_FIX = {32'hCAFEBABE, 32'h3344555A, 32'h11112222};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [31:0]   m_addr = '0;
    logic          m_wren = 1'b0;
    logic          m_strobe = 1'b0;
    logic          m_wait;
    logic [31:0]   m_rddata;
    logic          m_error;
    logic [N-1:0]  s_strobe;
    logic [N-1:0]  s_wait = '0;
    logic [95:0]   s_rddata = '0;
    logic [1:0]    dbg_state;

    aq32_bus_interconnect #(
        .NUM_SLAVES (N),
        .SLV_BASE   (BASE),
        .SLV_MASK   (MASK),
        .SYNC_RD    (SYNC),
        .BYTE_RD    (BYTE),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_addr    (m_addr),
        .m_wren    (m_wren),
        .m_strobe  (m_strobe),
        .m_wait    (m_wait),
        .m_rddata  (m_rddata),
        .m_error   (m_error),
        .s_strobe  (s_strobe),
        .s_wait    (s_wait),
        .s_rddata  (s_rddata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: cycles spent in the current transaction, and consecutive slave-wait cycles.
    int md_age   = 0;
    int md_waits = 0;

    logic          e_wait, e_error;
    logic [31:0]   e_rd;
    logic [N-1:0]  e_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The first window (in ascending order) that contains the address, or -1 if none does.
    function automatic int decode(input logic [31:0] a);
        logic [31:0] b, m;
        for (int k = 0; k < N; k++) begin
            b = BASE[32*k +: 32];
            m = MASK[32*k +: 32];
            if ((a & m) == b) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] lane(input int k);
        logic [31:0] w;
        w = s_rddata[32*k +: 32];
        return BYTE[k] ? {4{w[7:0]}} : w;
    endfunction

    // Predict this cycle's outputs from the transaction rules, then advance the model.
    task automatic model_step();
        int  sel;
        bit  done;
        done     = 1'b0;
        e_wait   = 1'b0;
        e_error  = 1'b0;
        e_rd     = '0;
        e_strobe = '0;
        if (!reset_n || !m_strobe) begin
            md_age   = 0;
            md_waits = 0;
            return;
        end
        sel = decode(m_addr);
        if (sel < 0) begin
            if (md_age == 0) e_wait = 1'b1;
            else begin e_error = 1'b1; done = 1'b1; end
        end else if (SYNC[sel]) begin
            e_strobe[sel] = 1'b1;
            if (!m_wren) e_rd = lane(sel);
            if (m_wren || md_age >= 1) done = 1'b1;
            else e_wait = 1'b1;
        end else if (md_waits == TO) begin
            e_error = 1'b1;
            done    = 1'b1;
        end else begin
            e_strobe[sel] = 1'b1;
            e_wait        = s_wait[sel];
            if (!m_wren) e_rd = lane(sel);
            if (s_wait[sel]) md_waits++;
            else done = 1'b1;
        end
        if (done) begin
            md_age   = 0;
            md_waits = 0;
        end else begin
            md_age++;
        end
    endtask

    // driver: one bus cycle. Inputs change on the falling edge, and outputs are compared just after it.
    task automatic cyc(input logic rst, input logic str, input logic [31:0] a, input logic wr,
                       input logic [N-1:0] sw, input logic [95:0] rd);
        @(negedge clk);
        reset_n  = rst;
        m_strobe = str;
        m_addr   = a;
        m_wren   = wr;
        s_wait   = sw;
        s_rddata = rd;
        #2;
        model_step();
        check("m_wait",   32'(m_wait),   32'(e_wait));
        check("m_error",  32'(m_error),  32'(e_error));
        check("m_rddata", m_rddata,      e_rd);
        check("s_strobe", 32'(s_strobe), 32'(e_strobe));
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 3'b000, RD_FIX);
    endtask

    logic [31:0] cur_a;
    logic        cur_wr;
    logic        stuck;

    initial begin
        // Reset forces all outputs to 0 even with strobe high.
        cyc(1'b0, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("rst_wait", 32'(m_wait), 32'h0);
        check("rst_strobe", 32'(s_strobe), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);

        // Read from the registered-read slave: two strobed cycles, and data in the second.
        cyc(1'b1, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("sync_c0_strobe", 32'(s_strobe), 32'h4);
        check("sync_c0_wait", 32'(m_wait), 32'h1);
        cyc(1'b1, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("sync_c1_strobe", 32'(s_strobe), 32'h4);
        check("sync_c1_wait", 32'(m_wait), 32'h0);
        check("sync_c1_data", m_rddata, 32'hCAFEBABE);
        idle();

        // Byte slave: the write completes at once, and the read replicates the low byte.
        cyc(1'b1, 1'b1, 32'hFF000010, 1'b1, 3'b000, RD_FIX);
        check("byte_wr_strobe", 32'(s_strobe), 32'h2);
        check("byte_wr_wait", 32'(m_wait), 32'h0);
        cyc(1'b1, 1'b1, 32'hFF000010, 1'b0, 3'b000, RD_FIX);
        check("byte_rd_data", m_rddata, 32'h5A5A5A5A);
        idle();

        // Unmapped read: one wait cycle, then an error.
        cyc(1'b1, 1'b1, 32'h00001000, 1'b0, 3'b000, RD_FIX);
        check("unm_c0_strobe", 32'(s_strobe), 32'h0);
        check("unm_c0_wait", 32'(m_wait), 32'h1);
        cyc(1'b1, 1'b1, 32'h00001000, 1'b0, 3'b000, RD_FIX);
        check("unm_c1_error", 32'(m_error), 32'h1);
        check("unm_c1_wait", 32'(m_wait), 32'h0);
        idle();

        // Slave 0 stuck: eight wait cycles, then a timeout error with no strobe.
        for (int i = 0; i < TO; i++) begin
            cyc(1'b1, 1'b1, 32'hFFF00000, 1'b0, 3'b001, RD_FIX);
            check("to_wait", 32'(m_wait), 32'h1);
        end
        cyc(1'b1, 1'b1, 32'hFFF00000, 1'b0, 3'b001, RD_FIX);
        check("to_error", 32'(m_error), 32'h1);
        check("to_wait_end", 32'(m_wait), 32'h0);
        check("to_strobe", 32'(s_strobe), 32'h0);
        idle();
        check("to_state_idle", 32'(dbg_state), 32'h0);

        // Three wait cycles, then completion. The strobe stays high, so the next
        // back-to-back access must get the full timeout again.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'hFFF00040, 1'b0, 3'b001, RD_FIX);
        cyc(1'b1, 1'b1, 32'hFFF00040, 1'b0, 3'b000, RD_FIX);
        check("w3_wait", 32'(m_wait), 32'h0);
        check("w3_error", 32'(m_error), 32'h0);
        check("w3_data", m_rddata, 32'h11112222);
        for (int i = 0; i < TO; i++) cyc(1'b1, 1'b1, 32'hFFF00040, 1'b0, 3'b001, RD_FIX);
        check("b2b_wait_last", 32'(m_wait), 32'h1);
        cyc(1'b1, 1'b1, 32'hFFF00040, 1'b0, 3'b001, RD_FIX);
        check("b2b_to_error", 32'(m_error), 32'h1);
        idle();

        // Reset asserted in the middle of a registered read.
        cyc(1'b1, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        cyc(1'b0, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("rst_sync_data", m_rddata, 32'h0);
        check("rst_sync_state", 32'(dbg_state), 32'h0);
        cyc(1'b1, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("post_rst_wait", 32'(m_wait), 32'h1);
        cyc(1'b1, 1'b1, 32'hFFFFF804, 1'b0, 3'b000, RD_FIX);
        check("post_rst_data", m_rddata, 32'hCAFEBABE);
        idle();

        // Randomized traffic. Address and direction are held while a transaction is open,
        // and occasional aborts and reset pulses are mixed in.
        cur_a  = '0;
        cur_wr = 1'b0;
        stuck  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic         str;
            logic [N-1:0] sw;
            logic         rst;
            if (md_age > 0) begin
                str = ($urandom_range(0, 99) < 96);
            end else begin
                str = ($urandom_range(0, 99) < 85);
                case ($urandom_range(0, 3))
                    0:       cur_a = 32'hFFF00000 | ($urandom & 32'h0007FFFF);
                    1:       cur_a = 32'hFF000000 | ($urandom & 32'h00000FFF);
                    2:       cur_a = 32'hFFFFF800 | ($urandom & 32'h000007FF);
                    default: cur_a = $urandom & 32'h00FFFFFF;
                endcase
                cur_wr = $urandom_range(0, 1) == 1;
                stuck  = $urandom_range(0, 5) == 0;
            end
            sw = N'($urandom_range(0, 7));
            if (stuck) sw[0] = 1'b1;
            rst = ($urandom_range(0, 199) != 0);
            cyc(rst, str, cur_a, cur_wr, sw, {$urandom, $urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
